// File: rtl/tiny32_timer.sv
`default_nettype none
// ============================================================================
// Module   : tiny32_timer
// Purpose  : Memory-mapped 32-bit timer/compare peripheral for the tiny32
//            ports region. Prescaled counter, compare match with periodic or
//            one-shot mode, one level interrupt with CPU acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module tiny32_timer #(
    parameter int          PRESCALE_BITS = 16,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        sel,
    input  logic [2:0]  address,
    input  logic        nrd,
    input  logic [3:0]  nwr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        interrupt,
    input  logic        interrupt_ack
);

    // Register word offsets
    localparam logic [2:0] c_ADDR_CTRL     = 3'd0;
    localparam logic [2:0] c_ADDR_PRESCALE = 3'd1;
    localparam logic [2:0] c_ADDR_COMPARE  = 3'd2;
    localparam logic [2:0] c_ADDR_COUNTER  = 3'd3;
    localparam logic [2:0] c_ADDR_STATUS   = 3'd4;

    // CTRL bit positions
    localparam int c_BIT_EN       = 0;
    localparam int c_BIT_PERIODIC = 1;
    localparam int c_BIT_IE       = 2;

    localparam logic [PRESCALE_BITS-1:0] c_PRE_ONE = {{(PRESCALE_BITS-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]               r_ctrl;
    logic [PRESCALE_BITS-1:0] r_prescale;
    logic [31:0]              r_compare;
    logic [31:0]              r_counter;
    logic                     r_match;
    logic [PRESCALE_BITS-1:0] r_pre_cnt;
    logic                     r_active_d;
    logic                     r_armed;
    logic [31:0]              r_data_out;

    // ------------------------------------------------------------------------
    // Bus access decode
    // ------------------------------------------------------------------------
    logic                     w_active;
    logic                     w_fire;
    logic                     w_rd_fire;
    logic                     w_wr_fire;
    logic [31:0]              w_lane_mask;
    logic [2:0]               w_ctrl_wr;
    logic [PRESCALE_BITS-1:0] w_prescale_wr;
    logic [31:0]              w_compare_wr;
    logic [31:0]              w_counter_wr;
    logic                     w_status_clr;
    logic                     w_tick;
    logic                     w_hit;
    logic                     w_match_set;
    logic [31:0]              w_rd_data;

    assign w_active = !nrd || (nwr != 4'hF);

    // One action per CPU access: only the rising edge of the strobe fires.
    // r_armed keeps a strobe that was already held across reset release
    // from being taken as a new access.
    assign w_fire    = sel && w_active && !r_active_d && r_armed;
    assign w_rd_fire = w_fire && !nrd;
    assign w_wr_fire = w_fire && (nwr != 4'hF);

    assign w_lane_mask = {{8{~nwr[3]}}, {8{~nwr[2]}}, {8{~nwr[1]}}, {8{~nwr[0]}}};

    assign w_ctrl_wr     = (r_ctrl & ~w_lane_mask[2:0]) | (data_in[2:0] & w_lane_mask[2:0]);
    assign w_prescale_wr = (r_prescale & ~w_lane_mask[PRESCALE_BITS-1:0])
                         | (data_in[PRESCALE_BITS-1:0] & w_lane_mask[PRESCALE_BITS-1:0]);
    assign w_compare_wr  = (r_compare & ~w_lane_mask) | (data_in & w_lane_mask);
    assign w_counter_wr  = (r_counter & ~w_lane_mask) | (data_in & w_lane_mask);

    assign w_status_clr = w_wr_fire && (address == c_ADDR_STATUS) && !nwr[0] && data_in[0];

    // ------------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------------
    assign w_tick      = r_ctrl[c_BIT_EN] && (r_pre_cnt == r_prescale);
    assign w_hit       = (r_counter == r_compare);
    assign w_match_set = w_tick && w_hit;

    assign interrupt = r_match && r_ctrl[c_BIT_IE];
    assign data_out  = r_data_out;

    // Read mux; unimplemented bits and offsets read as zero
    always_comb begin
        w_rd_data = 32'd0;
        case (address)
            c_ADDR_CTRL:     w_rd_data[2:0]               = r_ctrl;
            c_ADDR_PRESCALE: w_rd_data[PRESCALE_BITS-1:0] = r_prescale;
            c_ADDR_COMPARE:  w_rd_data                    = r_compare;
            c_ADDR_COUNTER:  w_rd_data                    = r_counter;
            c_ADDR_STATUS:   w_rd_data[0]                 = r_match;
            default:         w_rd_data                    = 32'd0;
        endcase
    end

    // Strobe edge detection and post-reset arming
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_active_d <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_active_d <= w_active;
            if (!w_active)
                r_armed <= 1'b1;
        end
    end

    // Read data register, loaded only when a read fires
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            r_data_out <= 32'd0;
        else if (w_rd_fire)
            r_data_out <= w_rd_data;
    end

    // CTRL: CPU write wins over the one-shot EN clear
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            r_ctrl <= 3'd0;
        else if (w_wr_fire && (address == c_ADDR_CTRL))
            r_ctrl <= w_ctrl_wr;
        else if (w_match_set && !r_ctrl[c_BIT_PERIODIC])
            r_ctrl[c_BIT_EN] <= 1'b0;
    end

    // PRESCALE and COMPARE are plain CPU-written registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_prescale <= '0;
            r_compare  <= RESET_COMPARE;
        end else if (w_wr_fire) begin
            if (address == c_ADDR_PRESCALE)
                r_prescale <= w_prescale_wr;
            if (address == c_ADDR_COMPARE)
                r_compare <= w_compare_wr;
        end
    end

    // Prescaler; held at zero while disabled, so enabling always starts from 0
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            r_pre_cnt <= '0;
        else if (!r_ctrl[c_BIT_EN] || w_tick)
            r_pre_cnt <= '0;
        else
            r_pre_cnt <= r_pre_cnt + c_PRE_ONE;
    end

    // Main counter: CPU write beats tick; wraps silently at all-ones
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            r_counter <= 32'd0;
        else if (w_wr_fire && (address == c_ADDR_COUNTER))
            r_counter <= w_counter_wr;
        else if (w_tick) begin
            if (w_hit) begin
                if (r_ctrl[c_BIT_PERIODIC])
                    r_counter <= 32'd0;
            end else begin
                r_counter <= r_counter + 32'd1;
            end
        end
    end

    // MATCH flag: a new match beats acknowledge and write-one-to-clear
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            r_match <= 1'b0;
        else if (w_match_set)
            r_match <= 1'b1;
        else if (interrupt_ack || w_status_clr)
            r_match <= 1'b0;
    end

endmodule
`default_nettype wire
